// File: rtl/sha256_pkg.sv
// Shared SHA-256 state definitions: word width, words per hash state, word type.
package sha256_pkg;
   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 8;

   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/memory_switch_word.sv
// One state word: 2:1 bank mux feeding a register with asynchronous clear.
module memory_switch_word #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic [WIDTH-1:0] d_1,
   input  logic [WIDTH-1:0] d_2,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else     q <= sel ? d_2 : d_1;
   end

endmodule

// File: rtl/memory_switch.sv
// Registered 2:1 selector between two A..H hash-state banks; all eight words
// share one select so the working state always comes from a single bank.
module memory_switch
   import sha256_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             addr,
   input  logic [WIDTH-1:0] in_A_1,
   input  logic [WIDTH-1:0] in_B_1,
   input  logic [WIDTH-1:0] in_C_1,
   input  logic [WIDTH-1:0] in_D_1,
   input  logic [WIDTH-1:0] in_E_1,
   input  logic [WIDTH-1:0] in_F_1,
   input  logic [WIDTH-1:0] in_G_1,
   input  logic [WIDTH-1:0] in_H_1,
   input  logic [WIDTH-1:0] in_A_2,
   input  logic [WIDTH-1:0] in_B_2,
   input  logic [WIDTH-1:0] in_C_2,
   input  logic [WIDTH-1:0] in_D_2,
   input  logic [WIDTH-1:0] in_E_2,
   input  logic [WIDTH-1:0] in_F_2,
   input  logic [WIDTH-1:0] in_G_2,
   input  logic [WIDTH-1:0] in_H_2,
   output logic [WIDTH-1:0] out_A,
   output logic [WIDTH-1:0] out_B,
   output logic [WIDTH-1:0] out_C,
   output logic [WIDTH-1:0] out_D,
   output logic [WIDTH-1:0] out_E,
   output logic [WIDTH-1:0] out_F,
   output logic [WIDTH-1:0] out_G,
   output logic [WIDTH-1:0] out_H
);

   // index 0 = word A ... index 7 = word H
   logic [NUM_WORDS-1:0][WIDTH-1:0] bank_1, bank_2, word_q;

   assign bank_1 = {in_H_1, in_G_1, in_F_1, in_E_1, in_D_1, in_C_1, in_B_1, in_A_1};
   assign bank_2 = {in_H_2, in_G_2, in_F_2, in_E_2, in_D_2, in_C_2, in_B_2, in_A_2};

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      memory_switch_word #(.WIDTH(WIDTH)) u_word (
         .clk (clk),
         .rst (rst),
         .sel (addr),
         .d_1 (bank_1[w]),
         .d_2 (bank_2[w]),
         .q   (word_q[w])
      );
   end

   assign out_A = word_q[0];
   assign out_B = word_q[1];
   assign out_C = word_q[2];
   assign out_D = word_q[3];
   assign out_E = word_q[4];
   assign out_F = word_q[5];
   assign out_G = word_q[6];
   assign out_H = word_q[7];

endmodule

// File: tb/tb_memory_switch.sv
// Self-checking bench for memory_switch: directed cases plus random traffic
// against a per-edge bank-select reference model.
module tb_memory_switch;
   import sha256_pkg::*;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  addr = 1'b0;
   word_t b1 [8];
   word_t b2 [8];
   word_t outs [8];
   word_t exp_q [8];
   int    n_vec = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   memory_switch #(.WIDTH(WORD_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .in_A_1 (b1[0]), .in_B_1 (b1[1]), .in_C_1 (b1[2]), .in_D_1 (b1[3]),
      .in_E_1 (b1[4]), .in_F_1 (b1[5]), .in_G_1 (b1[6]), .in_H_1 (b1[7]),
      .in_A_2 (b2[0]), .in_B_2 (b2[1]), .in_C_2 (b2[2]), .in_D_2 (b2[3]),
      .in_E_2 (b2[4]), .in_F_2 (b2[5]), .in_G_2 (b2[6]), .in_H_2 (b2[7]),
      .out_A  (outs[0]), .out_B (outs[1]), .out_C (outs[2]), .out_D (outs[3]),
      .out_E  (outs[4]), .out_F (outs[5]), .out_G (outs[6]), .out_H (outs[7])
   );

   task automatic chk(input string tag, input word_t obs, input word_t expv);
      n_vec++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_all(input string tag);
      for (int w = 0; w < 8; w++)
         chk($sformatf("%s word %s", tag, string'(8'("A" + w))), outs[w], exp_q[w]);
   endtask

   // Reference: on each rising edge out of reset, the whole state is copied
   // from the bank addr names; reset clears it at once.
   task automatic tick();
      @(posedge clk);
      for (int w = 0; w < 8; w++)
         exp_q[w] = rst ? '0 : (addr ? b2[w] : b1[w]);
      #1;
   endtask

   task automatic set_rst(input logic v);
      rst = v;
      if (v) for (int w = 0; w < 8; w++) exp_q[w] = '0;
      #1;
   endtask

   task automatic rand_banks();
      for (int w = 0; w < 8; w++) begin
         b1[w] = $urandom;
         b2[w] = $urandom;
      end
   endtask

   initial begin
      for (int w = 0; w < 8; w++) exp_q[w] = '0;
      rand_banks();
      addr = 1'($urandom);
      #1;
      chk_all("reset_pre_edge");
      for (int c = 0; c < 3; c++) begin
         rand_banks();
         addr = 1'($urandom);
         tick();
         chk_all("reset_held");
      end

      // small directed values
      set_rst(1'b0);
      addr = 1'b0;
      for (int w = 0; w < 8; w++) begin b1[w] = '0; b2[w] = '0; end
      b1[0] = 32'h1; b1[1] = 32'h2; b2[0] = 32'hF; b2[1] = 32'h7;
      tick();
      chk_all("bank1_small");
      addr = 1'b1;
      #2;
      chk_all("addr_change_no_edge");
      tick();
      chk_all("bank2_small");

      // distinct per-word pattern, inverse in bank 2, toggle addr
      for (int w = 0; w < 8; w++) begin
         b1[w] = 32'h11111111 * (w + 1);
         b2[w] = ~b1[w];
      end
      for (int c = 0; c < 8; c++) begin
         addr = c[0];
         tick();
         chk_all($sformatf("toggle_%0d", c));
      end

      // mid-cycle reset with nonzero outputs
      rand_banks();
      addr = 1'b0;
      tick();
      chk_all("pre_async_rst");
      #2;
      set_rst(1'b1);
      chk_all("async_rst_mid_cycle");
      tick();
      chk_all("rst_held_edge");
      set_rst(1'b0);
      addr = 1'b1;
      tick();
      chk_all("reload_after_rst");

      // full width
      for (int w = 0; w < 8; w++) b2[w] = '1;
      addr = 1'b1;
      tick();
      chk_all("all_ones_bank2");

      // random traffic with input wiggles between edges and occasional resets
      for (int c = 0; c < 300; c++) begin
         rand_banks();
         addr = 1'($urandom);
         if ($urandom_range(0, 19) == 0) set_rst(1'b1);
         else if (rst) set_rst(1'b0);
         tick();
         chk_all("random");
         rand_banks();
         addr = ~addr;
         #2;
         chk_all("random_between_edges");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
